// File: rtl/config_pkg.sv
// rtl/config_pkg.sv - opcode constants, header size and FSM state type for alu_resp_tx (RESP_CHECKSUM_EN adds CSUM)
package config_pkg;

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hAD;
  localparam logic [7:0] OP_MUL  = 8'hAC;
  localparam logic [7:0] OP_DIV  = 8'hD1;

  localparam int RESP_HDR_BYTES = 4;

`ifdef RESP_CHECKSUM_EN
  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA, ST_CSUM} resp_state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA} resp_state_t;
`endif

endpackage

// File: rtl/alu_resp_tx.sv
// rtl/alu_resp_tx.sv - ALU result to UART TX byte serializer; RESP_CHECKSUM_EN appends an XOR checksum byte
module alu_resp_tx
  import config_pkg::*;
#(
  parameter int         DATA_W    = 32,
  parameter logic [7:0] RSVD_BYTE = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        opcode_i,
  input  logic [DATA_W-1:0] result_i,
  input  logic              result_valid_i,
  output logic              result_ready_o,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              busy_o
);

  localparam int DATA_BYTES = DATA_W / 8;
`ifdef RESP_CHECKSUM_EN
  localparam logic [15:0] LEN = 16'(RESP_HDR_BYTES + DATA_BYTES + 1);
`else
  localparam logic [15:0] LEN = 16'(RESP_HDR_BYTES + DATA_BYTES);
`endif
  localparam logic [2:0] HDR_LAST  = 3'(RESP_HDR_BYTES - 1);
  localparam logic [2:0] DATA_LAST = 3'(DATA_BYTES - 1);

  resp_state_t       state, state_d;
  logic [2:0]        idx, idx_d;
  logic [DATA_W-1:0] cap_result, cap_result_d;
  logic [7:0]        tx_data_d;
  logic              tx_valid_d;
  logic              xfer;
`ifdef RESP_CHECKSUM_EN
  logic [7:0]        csum, csum_d;
`endif

  assign xfer           = tx_valid_o && tx_ready_i;
  assign result_ready_o = (state == ST_IDLE);
  assign busy_o         = (state != ST_IDLE);

  // Header byte that follows the one currently at index i.
  function automatic logic [7:0] hdr_next(input logic [2:0] i);
    case (i)
      3'd0:    hdr_next = RSVD_BYTE;
      3'd1:    hdr_next = LEN[7:0];
      default: hdr_next = LEN[15:8];
    endcase
  endfunction

  always_comb begin
    state_d      = state;
    idx_d        = idx;
    cap_result_d = cap_result;
    tx_data_d    = tx_data_o;
    tx_valid_d   = tx_valid_o;
`ifdef RESP_CHECKSUM_EN
    csum_d       = csum;
    if (xfer) csum_d = csum ^ tx_data_o;
`endif

    // The next byte is loaded into tx_data_o on the transfer of the current one.
    case (state)
      ST_IDLE: begin
        if (result_valid_i && result_ready_o) begin
          cap_result_d = result_i;
          tx_data_d    = opcode_i;
          tx_valid_d   = 1'b1;
          idx_d        = 3'd0;
          state_d      = ST_HDR;
`ifdef RESP_CHECKSUM_EN
          csum_d       = 8'h00;
`endif
        end
      end

      ST_HDR: begin
        if (xfer) begin
          if (idx == HDR_LAST) begin
            tx_data_d    = cap_result[7:0];
            cap_result_d = cap_result >> 8;
            idx_d        = 3'd0;
            state_d      = ST_DATA;
          end else begin
            tx_data_d = hdr_next(idx);
            idx_d     = idx + 3'd1;
          end
        end
      end

      ST_DATA: begin
        if (xfer) begin
          if (idx == DATA_LAST) begin
`ifdef RESP_CHECKSUM_EN
            tx_data_d = csum ^ tx_data_o;
            state_d   = ST_CSUM;
`else
            tx_data_d  = 8'h00;
            tx_valid_d = 1'b0;
            state_d    = ST_IDLE;
`endif
          end else begin
            tx_data_d    = cap_result[7:0];
            cap_result_d = cap_result >> 8;
            idx_d        = idx + 3'd1;
          end
        end
      end

`ifdef RESP_CHECKSUM_EN
      ST_CSUM: begin
        if (xfer) begin
          tx_data_d  = 8'h00;
          tx_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
`endif

      default: begin
        tx_data_d  = 8'h00;
        tx_valid_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      idx        <= 3'd0;
      cap_result <= '0;
      tx_data_o  <= 8'h00;
      tx_valid_o <= 1'b0;
`ifdef RESP_CHECKSUM_EN
      csum       <= 8'h00;
`endif
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      cap_result <= cap_result_d;
      tx_data_o  <= tx_data_d;
      tx_valid_o <= tx_valid_d;
`ifdef RESP_CHECKSUM_EN
      csum       <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_resp_tx.sv
// tb/tb_alu_resp_tx.sv - self-checking bench for alu_resp_tx (honours RESP_CHECKSUM_EN)
module tb_alu_resp_tx;

  localparam int DATA_W = 32;
  localparam int NB     = DATA_W / 8;
`ifdef RESP_CHECKSUM_EN
  localparam int PLEN = 5 + NB;
`else
  localparam int PLEN = 4 + NB;
`endif

  typedef logic [7:0] bq_t[$];

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        opcode_i;
  logic [DATA_W-1:0] result_i;
  logic              result_valid_i;
  logic              result_ready_o;
  logic [7:0]        tx_data_o;
  logic              tx_valid_o;
  logic              tx_ready_i;
  logic              busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_resp_tx #(.DATA_W(DATA_W), .RSVD_BYTE(8'h00)) dut (
    .clk            (clk),
    .rst            (rst),
    .opcode_i       (opcode_i),
    .result_i       (result_i),
    .result_valid_i (result_valid_i),
    .result_ready_o (result_ready_o),
    .tx_data_o      (tx_data_o),
    .tx_valid_o     (tx_valid_o),
    .tx_ready_i     (tx_ready_i),
    .busy_o         (busy_o)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference packet: header, result bytes LSB first, optional running XOR.
  function automatic bq_t model_pkt(input logic [7:0] op, input logic [DATA_W-1:0] res);
    bq_t q;
    logic [7:0] x;
    q.push_back(op);
    q.push_back(8'h00);
    q.push_back(8'(PLEN % 256));
    q.push_back(8'(PLEN / 256));
    for (int i = 0; i < NB; i++) q.push_back(8'(res >> (8 * i)));
`ifdef RESP_CHECKSUM_EN
    x = 8'h00;
    foreach (q[i]) x = x ^ q[i];
    q.push_back(x);
`endif
    return q;
  endfunction

  task automatic accept(input logic [7:0] op, input logic [DATA_W-1:0] res);
    int n = 0;
    while (!result_ready_o && n < 50) begin
      tick();
      n++;
    end
    check("accept_ready", result_ready_o, 1);
    opcode_i       = op;
    result_i       = res;
    result_valid_i = 1'b1;
    tick();
    result_valid_i = 1'b0;
  endtask

  // tx_ready_i held high: byte k must appear in cycle N+1+k, idle in N+LEN+1.
  // inject >= 0 pulses a foreign result while byte index inject is shown.
  task automatic run_strict(input logic [7:0] op, input logic [DATA_W-1:0] res, input int inject);
    bq_t exp;
    exp = model_pkt(op, res);
    tx_ready_i = 1'b1;
    accept(op, res);
    for (int k = 0; k < PLEN; k++) begin
      check("strict_valid", tx_valid_o, 1);
      check("strict_byte", tx_data_o, exp[k]);
      check("strict_busy", busy_o, 1);
      check("strict_rdy_low", result_ready_o, 0);
      if (k == inject) begin
        opcode_i       = 8'hD1;
        result_i       = '1;
        result_valid_i = 1'b1;
      end else begin
        result_valid_i = 1'b0;
      end
      tick();
    end
    result_valid_i = 1'b0;
    check("end_valid", tx_valid_o, 0);
    check("end_ready", result_ready_o, 1);
  endtask

  task automatic run_random(input logic [7:0] op, input logic [DATA_W-1:0] res);
    bq_t exp;
    bq_t got;
    int n = 0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    exp = model_pkt(op, res);
    tx_ready_i = 1'b1;
    accept(op, res);
    while (got.size() < PLEN && n < 400) begin
      if (prev_stall) check("stall_hold_data", tx_data_o, prev_data);
      check("rand_valid", tx_valid_o, 1);
      tx_ready_i = ($urandom_range(0, 3) != 0);
      prev_stall = tx_valid_o && !tx_ready_i;
      prev_data  = tx_data_o;
      if (tx_valid_o && tx_ready_i) got.push_back(tx_data_o);
      tick();
      n++;
    end
    check("rand_count", got.size(), PLEN);
    for (int i = 0; i < PLEN; i++)
      if (i < got.size()) check("rand_byte", got[i], exp[i]);
    check("rand_end_valid", tx_valid_o, 0);
    check("rand_end_ready", result_ready_o, 1);
    tx_ready_i = 1'b1;
  endtask

  initial begin
    bq_t exp;
    logic [DATA_W-1:0] r;

    rst            = 1'b0;
    opcode_i       = 8'h00;
    result_i       = '0;
    result_valid_i = 1'b0;
    tx_ready_i     = 1'b1;
    tick();
    tick();
    check("rst_valid", tx_valid_o, 0);
    check("rst_data", tx_data_o, 8'h00);
    check("rst_busy", busy_o, 0);
    rst = 1'b1;
    tick();
    check("post_rst_ready", result_ready_o, 1);
    check("post_rst_busy", busy_o, 0);

    // Known vector: AD / 12345678.
    run_strict(8'hAD, 32'h12345678, -1);

    // Backpressure while byte index 2 is presented.
    exp = model_pkt(8'hAD, 32'h12345678);
    accept(8'hAD, 32'h12345678);
    check("bp_b0", tx_data_o, exp[0]);
    tick();
    check("bp_b1", tx_data_o, exp[1]);
    tick();
    check("bp_b2", tx_data_o, exp[2]);
    tx_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", tx_valid_o, 1);
      check("bp_hold_data", tx_data_o, exp[2]);
    end
    tx_ready_i = 1'b1;
    tick();
    for (int k = 3; k < PLEN; k++) begin
      check("bp_valid", tx_valid_o, 1);
      check("bp_byte", tx_data_o, exp[k]);
      tick();
    end
    check("bp_end_valid", tx_valid_o, 0);

    // Foreign result offered during DATA byte 1 must be ignored.
    run_strict(8'hAC, 32'hCAFE_0042, 5);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ignore_no_pkt", tx_valid_o, 0);
      check("ignore_not_busy", busy_o, 0);
    end

    // Back-to-back with result_valid_i held: one bubble between packets.
    opcode_i       = 8'hEC;
    result_i       = 32'h0000_0001;
    result_valid_i = 1'b1;
    tick();
    opcode_i = 8'hAC;
    result_i = 32'hDEADBEEF;
    exp = model_pkt(8'hEC, 32'h0000_0001);
    for (int k = 0; k < PLEN; k++) begin
      check("b2b1_valid", tx_valid_o, 1);
      check("b2b1_byte", tx_data_o, exp[k]);
      tick();
    end
    check("b2b_bubble_valid", tx_valid_o, 0);
    check("b2b_bubble_ready", result_ready_o, 1);
    tick();
    result_valid_i = 1'b0;
    exp = model_pkt(8'hAC, 32'hDEADBEEF);
    for (int k = 0; k < PLEN; k++) begin
      check("b2b2_valid", tx_valid_o, 1);
      check("b2b2_byte", tx_data_o, exp[k]);
      tick();
    end
    check("b2b2_end_valid", tx_valid_o, 0);

    // Reset asserted while DATA byte 1 is presented.
    exp = model_pkt(8'hAC, 32'h0BAD_F00D);
    accept(8'hAC, 32'h0BAD_F00D);
    for (int k = 0; k < 5; k++) tick();
    check("pre_rst_byte", tx_data_o, exp[5]);
    #2 rst = 1'b0;
    #1;
    check("midrst_valid", tx_valid_o, 0);
    check("midrst_busy", busy_o, 0);
    tick();
    rst = 1'b1;
    tick();
    r = $urandom;
    run_strict(8'hEC, r, -1);

    // Random results and opcodes with random backpressure.
    for (int p = 0; p < 20; p++) begin
      r = $urandom;
      run_random(8'($urandom_range(0, 255)), r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_resp_tx.md
# alu_resp_tx

Response serializer between the ALU result and the UART transmitter. Accepts one ALU result plus its opcode per transaction over a valid/ready handshake. Emits the response packet one byte at a time to the UART TX byte interface, honouring TX backpressure. It is the outbound counterpart of the command path that feeds the ALU.

## Interface

Parameters:
- DATA_W, 32, result width in bits; must be a multiple of 8, 8..64.
- RSVD_BYTE, 8'h00, value sent in the reserved header byte.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, asynchronous assert, active-low (0 = reset).
- opcode_i  input  8  opcode of the result, sampled on accept.
- result_i  input  DATA_W  ALU result, sampled on accept.
- result_valid_i  input  1  result/opcode valid.
- result_ready_o  output  1  block can accept a result; high only in IDLE.
- tx_data_o  output  8  byte to UART TX.
- tx_valid_o  output  1  tx_data_o valid.
- tx_ready_i  input  1  UART TX accepts the byte this cycle.
- busy_o  output  1  high while a packet is in flight (state != IDLE).

## Operation

- Packet byte order:
  - opcode
  - RSVD_BYTE
  - LEN[7:0]
  - LEN[15:8]
  - result bytes, least-significant first (DATA_W/8 bytes)
  - checksum byte, only when enabled
- LEN is the total packet length in bytes including the header. Without the checksum, LEN = 4 + DATA_W/8 (8 for the default).
- States:
  - IDLE: result_ready_o=1, tx_valid_o=0. On result_valid_i && result_ready_o, capture opcode_i/result_i into registers, clear byte index, go to HDR.
  - HDR: send 4 header bytes; index 0..3. After index 3 is accepted, go to DATA.
  - DATA: send captured bytes; index 0..DATA_W/8-1. After the last byte is accepted, go to CSUM if enabled, else IDLE.
  - CSUM: send the checksum byte; on accept go to IDLE.
- A byte transfers on tx_valid_o && tx_ready_i; the index and state advance only on a transfer.
- result_valid_i is ignored outside IDLE. The captured registers do not change until the packet completes.
- Reset mid-packet: abort immediately and return to IDLE. The partial packet is not resumed.

## Timing

- Reset values:
  - state IDLE, tx_valid_o 0, tx_data_o 8'h00, busy_o 0.
  - result_ready_o 1 once rst deasserts.
  - Capture registers and checksum cleared to 0.
- tx_data_o and tx_valid_o are registered.
- Latency: accept in cycle N gives tx_valid_o=1 with the opcode byte in cycle N+1.
- With tx_ready_i held high, one byte per cycle. The last byte of the packet is presented in cycle N+LEN.
- The first cycle with tx_valid_o=0 after the last byte is cycle N+LEN+1. result_ready_o=1 in that same cycle, so back-to-back accept costs one bubble cycle.
- Once tx_valid_o rises, it and tx_data_o stay stable until the transfer. tx_valid_o never drops mid-packet.
- tx_valid_o does not depend combinationally on tx_ready_i.
- result_ready_o is combinational from state only, never from result_valid_i.

## Configuration

- RESP_CHECKSUM_EN defined:
  - CSUM state exists; LEN = 5 + DATA_W/8.
  - The checksum is the XOR of every preceding byte of the packet, accumulated as each byte transfers.
- RESP_CHECKSUM_EN undefined:
  - No CSUM state, no checksum register; LEN = 4 + DATA_W/8.

## Structure

- config_pkg holds:
  - opcode constants (8'hEC echo, 8'hAD add, 8'hAC multiply, 8'hD1 divide)
  - RESP_HDR_BYTES = 4
  - the state enum type for this block
- LEN is a localparam computed from DATA_W and the macro.
- Byte selection from the capture register is a shift-right by 8 on each DATA transfer; no barrel mux.
- No sub-module; the block is a single FSM with datapath.

## Test plan

- Default build, accept opcode 8'hAD, result 32'h12345678, tx_ready_i=1 -> bytes AD 00 08 00 78 56 34 12 on consecutive cycles N+1..N+8; result_ready_o=1 at N+9.
- RESP_CHECKSUM_EN, same stimulus -> AD 00 09 00 78 56 34 12 AC.
- Backpressure: tx_ready_i=0 for 5 cycles while byte index 2 (8'h08) is presented -> tx_valid_o stays 1, tx_data_o stays 8'h08, next byte 8'h00 appears only after the transfer.
- Ignore while busy: pulse result_valid_i with opcode 8'hD1, result 32'hFFFFFFFF during the DATA state -> current packet unchanged, no second packet.
- Back-to-back: result_valid_i held high with two results (EC/32'h0000_0001, then AC/32'hDEADBEEF) -> two complete packets with exactly one idle cycle between them.
- Assert rst during DATA byte 1 -> tx_valid_o=0 and busy_o=0 immediately. After release, a new accept produces a full, correct packet starting with its opcode byte.
